// File: rtl/vga_timing_gen_param.sv
// Parametrised raster timing generator: sync, active flag, coordinates, frame/vblank
// events and a next-line prefetch request, all registered from the new raster position.
module vga_timing_gen_param #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned FCNT_W   = 16,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_stb,
    input  logic              i_en,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_active,
    output logic [XW-1:0]     o_x,
    output logic [YW-1:0]     o_y,
    output logic              o_frame_start,
    output logic              o_vblank_start,
    output logic              o_line_req,
    output logic [YW-1:0]     o_req_y,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_ACTIVE < 2 || V_FP < 1 ||
        V_SYNC < 1 || V_BP < 1 || FCNT_W < 1) begin : g_param_check
        $error("vga_timing_gen_param: invalid timing parameters");
    end

    localparam logic [XW-1:0] XLast   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] XActive = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HsBeg   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HsEnd   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] YLast   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] YActive = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VsBeg   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VsEnd   = YW'(V_ACTIVE + V_FP + V_SYNC);

    // Internal raster position; the o_x/o_y copies reset to 0 independently.
    logic [XW-1:0]     x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]     y_q, y_d, oy_q, oy_d;
    logic              hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic              fs_q, fs_d, vb_q, vb_d, lr_q, lr_d;
    logic [YW-1:0]     ry_q, ry_d;
    logic [FCNT_W-1:0] fc_q, fc_d;

    logic          step, x_wrap;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_inc, y_nxt, y_req;

    always_comb begin
        step   = i_en & i_pix_stb;
        x_wrap = (x_q == XLast);
        x_nxt  = x_wrap ? '0 : x_q + 1'b1;
        y_inc  = (y_q == YLast) ? '0 : y_q + 1'b1;
        y_nxt  = x_wrap ? y_inc : y_q;
        y_req  = (y_nxt == YLast) ? '0 : y_nxt + 1'b1;

        x_d   = x_q;
        y_d   = y_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        act_d = act_q;
        ry_d  = ry_q;
        fc_d  = fc_q;
        fs_d  = 1'b0;
        vb_d  = 1'b0;
        lr_d  = 1'b0;

        if (step) begin
            x_d   = x_nxt;
            y_d   = y_nxt;
            ox_d  = x_nxt;
            oy_d  = y_nxt;
            hs_d  = ((x_nxt >= HsBeg) && (x_nxt < HsEnd)) ? HS_POL : ~HS_POL;
            vs_d  = ((y_nxt >= VsBeg) && (y_nxt < VsEnd)) ? VS_POL : ~VS_POL;
            act_d = (x_nxt < XActive) && (y_nxt < YActive);
            fs_d  = (x_nxt == '0) && (y_nxt == '0);
            vb_d  = (x_nxt == '0) && (y_nxt == YActive);
            if (vb_d) begin
                fc_d = fc_q + 1'b1;
            end
            // Prefetch the following line as horizontal blanking begins.
            lr_d = (x_nxt == XActive) && (y_req < YActive);
            if (lr_d) begin
                ry_d = y_req;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q   <= XLast;
            y_q   <= YLast;
            ox_q  <= '0;
            oy_q  <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            fs_q  <= 1'b0;
            vb_q  <= 1'b0;
            lr_q  <= 1'b0;
            ry_q  <= '0;
            fc_q  <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            ox_q  <= ox_d;
            oy_q  <= oy_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            fs_q  <= fs_d;
            vb_q  <= vb_d;
            lr_q  <= lr_d;
            ry_q  <= ry_d;
            fc_q  <= fc_d;
        end
    end

    assign o_hs           = hs_q;
    assign o_vs           = vs_q;
    assign o_active       = act_q;
    assign o_x            = ox_q;
    assign o_y            = oy_q;
    assign o_frame_start  = fs_q;
    assign o_vblank_start = vb_q;
    assign o_line_req     = lr_q;
    assign o_req_y        = ry_q;
    assign o_frame_cnt    = fc_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench for vga_timing_gen_param on a small raster (15 x 8) with a
// reference model feeding a scoreboard of expected per-cycle outputs.
module tb_vga_timing_gen_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_stb = 1'b0;
    logic       en = 1'b0;
    logic       hs, vs, act, fs, vb, lr;
    logic [3:0] x;
    logic [2:0] y, ry;
    logic [1:0] fc;

    vga_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .FCNT_W(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_en(en),
        .o_hs(hs), .o_vs(vs), .o_active(act), .o_x(x), .o_y(y),
        .o_frame_start(fs), .o_vblank_start(vb), .o_line_req(lr),
        .o_req_y(ry), .o_frame_cnt(fc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int hs; int vs; int act; int fs; int vb; int lr; int ry; int fc;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   mx, my;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx   = 14;
        my   = 7;
        held = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    endtask

    // Reference raster: positions walk x then y; decode straight from the timing table.
    task automatic model(bit s, bit e);
        held.fs = 0;
        held.vb = 0;
        held.lr = 0;
        if (s && e) begin
            mx++;
            if (mx == 15) begin
                mx = 0;
                my = (my + 1) % 8;
            end
            held.x   = mx;
            held.y   = my;
            held.hs  = (mx >= 10 && mx <= 12) ? 0 : 1;
            held.vs  = (my == 5 || my == 6) ? 1 : 0;
            held.act = (mx < 8 && my < 4) ? 1 : 0;
            held.fs  = (mx == 0 && my == 0) ? 1 : 0;
            held.vb  = (mx == 0 && my == 4) ? 1 : 0;
            if (held.vb == 1) held.fc = (held.fc + 1) % 4;
            if (mx == 8 && ((my + 1) % 8) < 4) begin
                held.lr = 1;
                held.ry = (my + 1) % 8;
            end
        end
        sb.push_back(held);
    endtask

    task automatic check_out(exp_t e);
        chk("x", x, e.x);
        chk("y", y, e.y);
        chk("hs", hs, e.hs);
        chk("vs", vs, e.vs);
        chk("active", act, e.act);
        chk("frame_start", fs, e.fs);
        chk("vblank_start", vb, e.vb);
        chk("line_req", lr, e.lr);
        chk("req_y", ry, e.ry);
        chk("frame_cnt", fc, e.fc);
    endtask

    task automatic cyc(bit s, bit e);
        pix_stb = s;
        en      = e;
        model(s, e);
        @(posedge clk);
        #1;
        check_out(sb.pop_front());
    endtask

    int act_cnt, req_cnt, pulse_cnt;
    int fcq[$];
    int fexp[5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_out(held);
        rst_n = 1'b1;

        // First step lands on (0,0)
        cyc(1, 1);
        chk("t1_x", x, 0);
        chk("t1_frame_start", fs, 1);
        chk("t1_active", act, 1);
        chk("t1_hs", hs, 1);
        chk("t1_vs", vs, 0);
        cyc(0, 1);

        // One full frame of constant strobe: returns to (0,0) after 120 steps
        act_cnt = 0;
        req_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            cyc(1, 1);
            if (act) act_cnt++;
            if (lr) req_cnt++;
        end
        chk("t2_frame_len", fs, 1);
        chk("t2_active_cnt", act_cnt, 32);
        chk("t3_req_cnt", req_cnt, 4);

        // Strobe every third clock
        for (int i = 0; i < 390; i++) cyc(i % 3 == 0, 1);

        // Freeze mid-line at x=5
        for (int i = 0; i < 15 && mx != 5; i++) cyc(1, 1);
        chk("t5_at_x5", x, 5);
        pulse_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0);
            if (fs || vb || lr) pulse_cnt++;
        end
        chk("t5_no_pulses", pulse_cnt, 0);
        cyc(1, 1);
        chk("t5_resume_x", x, 6);

        // Asynchronous reset mid-frame
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out(held);
        @(posedge clk);
        #1;
        check_out(held);
        rst_n = 1'b1;

        // Five frames: 2-bit frame counter wraps
        for (int i = 0; i < 600; i++) begin
            cyc(1, 1);
            if (vb) fcq.push_back(int'(fc));
        end
        chk("t6_vblank_cnt", fcq.size(), 5);
        for (int k = 0; k < 5 && k < fcq.size(); k++) chk("t6_frame_cnt_seq", fcq[k], fexp[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
